alu_sequencer: RTL
==================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL: CLK  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL: start  input  1  pulse; begins execution at PC 0 from IDLE or HALT.
REQ-004 SHALL: instr  input  9  instruction word at address pc; [8:5] opcode (op_mne encoding), [4:0] operand.
REQ-005 SHALL: pc  output  8  instruction address.
REQ-006 SHALL: alu_op  output  4  opcode to ALU, registered.
REQ-007 SHALL: alu_ci  output  1  carry flag register, fed to ALU carry in.
REQ-008 SHALL: alu_co / alu_z / alu_neg  input  1 each  ALU flag results.
REQ-009 SHALL: rf_addr  output  5  register index (operand field).
REQ-010 SHALL: sel_imm  output  1  1 = ALU in_a takes imm, 0 = register file.
REQ-011 SHALL: imm  output  8  zero-extended operand field.
REQ-012 SHALL: acc_we / rf_we  output  1 each  accumulator / register-file write enables.
REQ-013 SHALL: mem_re / mem_we  output  1 each  data-memory request strobes; mem_ready  input  1  completion.
REQ-014 SHALL: done  output  1  high while in HALT.

Function
REQ-015 SHALL: FSM states IDLE, FETCH, EXEC, MEMWAIT, HALT; IDLE->FETCH on start with pc=0.
REQ-016 SHALL: FETCH latches instr into instruction register (1 cycle); FETCH->EXEC always.
REQ-017 SHALL: EXEC drives alu_op from IR for exactly 1 cycle; non-memory instruction = 2 cycles FETCH+EXEC.
REQ-018 SHALL: kADD, kSUB, kAND, kXOR, kSHL, kSHR, kNOT, kLDI, kLDR: acc_we=1 in EXEC; flags C/Z/N capture alu_co/alu_z/alu_neg at end of EXEC.
REQ-019 SHALL: kLDI, kSHL, kSHR set sel_imm=1; all other register-operand ops set sel_imm=0.
REQ-020 SHALL: kSTR asserts rf_we in EXEC (acc -> register rf_addr); flags unchanged.
REQ-021 SHALL: kMLD/kMST assert mem_re/mem_we in EXEC, go MEMWAIT, hold strobe until mem_ready sampled high; kMLD asserts acc_we in the mem_ready cycle; MEMWAIT->FETCH.
REQ-022 SHALL: mem_ready high during EXEC completes the access in EXEC (no MEMWAIT).
REQ-023 SHALL: kJMP: pc <= pc + sign-extended operand[4:0], unconditional.
REQ-024 SHALL: kBRZ/kBRN: same target when Z/N flag register is 1, else pc+1.
REQ-025 SHALL: all other instructions pc <= pc+1 on leaving EXEC/MEMWAIT; pc arithmetic modulo 256 (255+1 -> 0).
REQ-026 SHALL: kCLR clears C, Z, N; kCLR with operand 5'h1F enters HALT, pc unchanged.
REQ-027 SHALL: start outside IDLE/HALT ignored; start in HALT restarts at pc 0, flags cleared.
REQ-028 SHALL: undefined opcodes treated as no-op (pc+1, flags unchanged).

Reset
REQ-029 SHALL: reset -> IDLE, pc=0, C=Z=N=0, IR=0, alu_op=kCLR; all enables, strobes and done 0 at next edge.
REQ-030 SHALL: reset dominates start and mem_ready; reset in MEMWAIT drops strobe next cycle, abandons access.

Configuration
REQ-031 SHALL: macro SEQ_PERF_CNT_EN defined adds outputs cyc_cnt[15:0] (cycles outside IDLE/HALT) and ret_cnt[15:0] (retired instructions), saturating at 16'hFFFF, cleared by reset and start.
REQ-032 SHALL: macro undefined removes both counters and ports; other behaviour identical.

Structure
REQ-033 SHALL: op_mne encodings come from definitions package; state enum seq_state_t and HALT operand constant added there.
REQ-034 SHALL: one sub-module, seq_branch_unit (combinational next-pc from pc, IR, flags).

Verification
REQ-035 SHALL: reset, start, kLDI 5 then kADD r1 (r1=3) -> acc_we pulses in cycles 2 and 4, pc=2 after cycle 4.
REQ-036 SHALL: kMLD with mem_ready delayed 3 cycles -> mem_re held 4 cycles, single acc_we, pc+1 after.
REQ-037 SHALL: Z=1 then kBRZ operand 5'h1E at pc=10 -> pc=8; Z=0 -> pc=11.
REQ-038 SHALL: kJMP +1 at pc=255 -> pc=0.
REQ-039 SHALL: kCLR 5'h1F -> done=1, pc frozen; start -> pc=0, done=0.
REQ-040 SHALL: reset asserted in MEMWAIT -> mem_re=0 next cycle, IDLE, all outputs at reset values.

Source files
------------

// File: rtl/alu_sequencer_pkg.sv
// alu_sequencer_pkg: shared definitions for the ALU sequencer.
// Holds the op_mne opcode encoding, the sequencer state enum, the halt
// operand constant and small decode/arithmetic helpers.
package alu_sequencer_pkg;

  // Opcode mnemonics, instr[8:5]
  typedef enum logic [3:0] {
    kADD = 4'h0,
    kSUB = 4'h1,
    kAND = 4'h2,
    kXOR = 4'h3,
    kSHL = 4'h4,
    kSHR = 4'h5,
    kNOT = 4'h6,
    kLDI = 4'h7,
    kLDR = 4'h8,
    kSTR = 4'h9,
    kMLD = 4'hA,
    kMST = 4'hB,
    kJMP = 4'hC,
    kBRZ = 4'hD,
    kBRN = 4'hE,
    kCLR = 4'hF
  } op_mne_t;

  // Sequencer control states
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_EXEC    = 3'd2,
    S_MEMWAIT = 3'd3,
    S_HALT    = 3'd4
  } seq_state_t;

  // kCLR with this operand stops the sequencer
  localparam logic [4:0]  HALT_OPERAND = 5'h1F;
  localparam logic [15:0] CNT_MAX      = 16'hFFFF;

  // Opcodes whose result lands in the accumulator and update C/Z/N
  function automatic logic writes_acc(input op_mne_t op);
    logic r;
    case (op)
      kADD, kSUB, kAND, kXOR, kSHL, kSHR, kNOT, kLDI, kLDR: r = 1'b1;
      default:                                              r = 1'b0;
    endcase
    return r;
  endfunction

  // Opcodes that feed the zero-extended operand to ALU in_a
  function automatic logic uses_imm(input op_mne_t op);
    logic r;
    case (op)
      kLDI, kSHL, kSHR: r = 1'b1;
      default:          r = 1'b0;
    endcase
    return r;
  endfunction

  // Saturating 16-bit increment
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == CNT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/alu_sequencer_branch_unit.sv
// seq_branch_unit: combinational next-pc selection for the ALU sequencer.
// Relative targets use the sign-extended 5-bit operand; all pc arithmetic
// wraps modulo 256. A halting kCLR keeps the pc where it is.
module seq_branch_unit
  import alu_sequencer_pkg::*;
(
  input  logic [7:0] pc,
  input  logic [8:0] ir,
  input  logic       flag_z,
  input  logic       flag_n,
  output logic [7:0] next_pc
);

  op_mne_t    op_s;
  logic [7:0] offset_s;
  logic [7:0] target_s;
  logic [7:0] seq_pc_s;

  assign op_s     = op_mne_t'(ir[8:5]);
  assign offset_s = {{3{ir[4]}}, ir[4:0]};
  assign target_s = pc + offset_s;
  assign seq_pc_s = pc + 8'd1;

  // Pick the pc of the next instruction from opcode and flag registers
  always_comb begin
    next_pc = seq_pc_s;
    case (op_s)
      kJMP: next_pc = target_s;
      kBRZ: begin
        if (flag_z) next_pc = target_s;
        else        next_pc = seq_pc_s;
      end
      kBRN: begin
        if (flag_n) next_pc = target_s;
        else        next_pc = seq_pc_s;
      end
      kCLR: begin
        if (ir[4:0] == HALT_OPERAND) next_pc = pc;
        else                         next_pc = seq_pc_s;
      end
      default: next_pc = seq_pc_s;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: fetch/execute controller driving an external ALU,
// register file and data memory.
// Optional feature: define SEQ_PERF_CNT_EN to add the cyc_cnt/ret_cnt
// performance counter outputs (saturating, cleared by reset and start).
module alu_sequencer
  import alu_sequencer_pkg::*;
(
  input  logic        CLK,
  input  logic        reset,
  input  logic        start,
  input  logic [8:0]  instr,
  output logic [7:0]  pc,
  output logic [3:0]  alu_op,
  output logic        alu_ci,
  input  logic        alu_co,
  input  logic        alu_z,
  input  logic        alu_neg,
  output logic [4:0]  rf_addr,
  output logic        sel_imm,
  output logic [7:0]  imm,
  output logic        acc_we,
  output logic        rf_we,
  output logic        mem_re,
  output logic        mem_we,
  input  logic        mem_ready,
  output logic        done
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [15:0] cyc_cnt,
  output logic [15:0] ret_cnt
`endif
);

  seq_state_t state_r;
  seq_state_t state_nxt_s;
  logic [7:0] pc_r;
  logic [8:0] ir_r;
  op_mne_t    alu_op_r;
  logic       flag_c_r;
  logic       flag_z_r;
  logic       flag_n_r;

  op_mne_t    op_s;
  logic [4:0] opnd_s;
  logic       mem_ld_s;
  logic       mem_st_s;
  logic       start_ok_s;
  logic       retire_s;
  logic [7:0] next_pc_s;

  assign op_s       = op_mne_t'(ir_r[8:5]);
  assign opnd_s     = ir_r[4:0];
  assign mem_ld_s   = (op_s == kMLD);
  assign mem_st_s   = (op_s == kMST);
  assign start_ok_s = start && ((state_r == S_IDLE) || (state_r == S_HALT));

  assign pc      = pc_r;
  assign alu_op  = alu_op_r;
  assign alu_ci  = flag_c_r;
  assign rf_addr = opnd_s;
  assign imm     = {3'b000, opnd_s};
  assign done    = (state_r == S_HALT);

  seq_branch_unit u_branch (
    .pc      (pc_r),
    .ir      (ir_r),
    .flag_z  (flag_z_r),
    .flag_n  (flag_n_r),
    .next_pc (next_pc_s)
  );

  // Next-state decode plus per-state enables and memory strobes
  always_comb begin
    state_nxt_s = state_r;
    acc_we      = 1'b0;
    rf_we       = 1'b0;
    sel_imm     = 1'b0;
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    retire_s    = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) state_nxt_s = S_FETCH;
        else       state_nxt_s = S_IDLE;
      end
      S_FETCH: begin
        state_nxt_s = S_EXEC;
      end
      S_EXEC: begin
        sel_imm = uses_imm(op_s);
        rf_we   = (op_s == kSTR);
        mem_re  = mem_ld_s;
        mem_we  = mem_st_s;
        if (mem_ld_s || mem_st_s) begin
          // A ready memory finishes the access without visiting MEMWAIT
          acc_we = mem_ld_s && mem_ready;
          if (mem_ready) begin
            state_nxt_s = S_FETCH;
            retire_s    = 1'b1;
          end else begin
            state_nxt_s = S_MEMWAIT;
          end
        end else begin
          acc_we   = writes_acc(op_s);
          retire_s = 1'b1;
          if ((op_s == kCLR) && (opnd_s == HALT_OPERAND)) state_nxt_s = S_HALT;
          else                                            state_nxt_s = S_FETCH;
        end
      end
      S_MEMWAIT: begin
        mem_re = mem_ld_s;
        mem_we = mem_st_s;
        acc_we = mem_ld_s && mem_ready;
        if (mem_ready) begin
          state_nxt_s = S_FETCH;
          retire_s    = 1'b1;
        end else begin
          state_nxt_s = S_MEMWAIT;
        end
      end
      S_HALT: begin
        if (start) state_nxt_s = S_FETCH;
        else       state_nxt_s = S_HALT;
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // State, pc, instruction register and the one-cycle alu_op register
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_r  <= S_IDLE;
      pc_r     <= 8'd0;
      ir_r     <= 9'd0;
      alu_op_r <= kCLR;
    end else begin
      state_r <= state_nxt_s;
      if (start_ok_s)    pc_r <= 8'd0;
      else if (retire_s) pc_r <= next_pc_s;
      else               pc_r <= pc_r;
      if (state_r == S_FETCH) ir_r <= instr;
      else                    ir_r <= ir_r;
      // alu_op carries the opcode only during EXEC, kCLR otherwise
      if (state_r == S_FETCH) alu_op_r <= op_mne_t'(instr[8:5]);
      else                    alu_op_r <= kCLR;
    end
  end

  // Carry/zero/negative flag registers
  always_ff @(posedge CLK) begin
    if (reset || start_ok_s) begin
      flag_c_r <= 1'b0;
      flag_z_r <= 1'b0;
      flag_n_r <= 1'b0;
    end else if ((state_r == S_EXEC) && writes_acc(op_s)) begin
      flag_c_r <= alu_co;
      flag_z_r <= alu_z;
      flag_n_r <= alu_neg;
    end else if ((state_r == S_EXEC) && (op_s == kCLR)) begin
      flag_c_r <= 1'b0;
      flag_z_r <= 1'b0;
      flag_n_r <= 1'b0;
    end else begin
      flag_c_r <= flag_c_r;
      flag_z_r <= flag_z_r;
      flag_n_r <= flag_n_r;
    end
  end

`ifdef SEQ_PERF_CNT_EN
  logic [15:0] cyc_cnt_r;
  logic [15:0] ret_cnt_r;

  assign cyc_cnt = cyc_cnt_r;
  assign ret_cnt = ret_cnt_r;

  // Active-cycle and retired-instruction counters, saturating
  always_ff @(posedge CLK) begin
    if (reset || start_ok_s) begin
      cyc_cnt_r <= 16'd0;
      ret_cnt_r <= 16'd0;
    end else begin
      if ((state_r == S_FETCH) || (state_r == S_EXEC) || (state_r == S_MEMWAIT))
        cyc_cnt_r <= sat_inc16(cyc_cnt_r);
      else
        cyc_cnt_r <= cyc_cnt_r;
      if (retire_s) ret_cnt_r <= sat_inc16(ret_cnt_r);
      else          ret_cnt_r <= ret_cnt_r;
    end
  end
`else
  // Counters not built: no extra state or ports in this configuration
`endif

endmodule
